// File: rtl/load_buffer.sv
// ============================================================================
//  Module   : load_buffer
//  Purpose  : Load functional unit for the Tomasulo core. Buffers ready loads
//             from the load reservation station, issues one data-BRAM read
//             at a time, and presents the sized/extended result with its ROB
//             index on a valid/read handshake toward the CDB writer.
//  Options  : LB_FLUSH_EN - adds flush_in, which squashes every pending and
//             in-flight load and any held result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module load_buffer #(
    parameter int DEPTH        = 4,   // pending-load FIFO entries, power of 2, >= 2
    parameter int READ_LATENCY = 2,   // data BRAM read latency in clocks, >= 1
    parameter int ADDR_WIDTH   = 6,   // data BRAM word-address bits
    parameter int ROB_IX_WIDTH = 3    // ROB index width
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    input  logic [31:0]             rval1_in,
    input  logic [31:0]             rval2_in,
    input  logic [2:0]              funct3_in,
    input  logic [ROB_IX_WIDTH-1:0] rob_ix_in,
    output logic                    ready_out,
    output logic                    mem_en_out,
    output logic [ADDR_WIDTH-1:0]   mem_addr_out,
    input  logic [31:0]             mem_data_in,
    input  logic                    read_in,
    output logic                    valid_out,
    output logic [31:0]             data_out,
    output logic [ROB_IX_WIDTH-1:0] rob_ix_out
`ifdef LB_FLUSH_EN
    ,
    input  logic                    flush_in
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_LAT_W = $clog2(READ_LATENCY + 1);
    // Only the word address plus the byte offset of the EA is ever needed.
    localparam int c_EA_W  = ADDR_WIDTH + 2;

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(READ_LATENCY);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(1);

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;

    logic [c_EA_W-1:0]       r_fifo_ea     [DEPTH];
    logic [2:0]              r_fifo_funct3 [DEPTH];
    logic [ROB_IX_WIDTH-1:0] r_fifo_rob    [DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [1:0]              r_inf_off;
    logic [2:0]              r_inf_funct3;
    logic [ROB_IX_WIDTH-1:0] r_inf_rob;

    logic [31:0]             w_ea;
    logic [31-c_EA_W:0]      w_unused_ea_hi;
    logic                    w_flush;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_capture;
    logic                    w_release;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_extract;

    // Effective address wraps at 32 bits; bits above the BRAM range are dropped.
    assign w_ea           = rval1_in + rval2_in;
    assign w_unused_ea_hi = w_ea[31:c_EA_W];

`ifdef LB_FLUSH_EN
    assign w_flush = flush_in;
`else
    // Without the flush option this is a constant and every flush term folds away.
    assign w_flush = 1'b0;
`endif

    // Flush has priority over a simultaneous push, so the push is dropped.
    assign w_push = valid_in && ready_out && !w_flush;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: request from IDLE, count down in WAIT, hold until read_in.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (!w_empty)                 w_state_nxt = c_WAIT;
                c_WAIT:  if (r_lat_cnt == c_LAT_LAST)  w_state_nxt = c_HOLD;
                c_HOLD:  if (read_in)                  w_state_nxt = c_IDLE;
                default:                               w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Outputs and control strobes decoded from registered state and count.
    always_comb begin
        w_empty      = (r_count == '0);
        ready_out    = (r_count != c_FULL);
        mem_en_out   = (r_state == c_IDLE) && !w_empty;
        mem_addr_out = r_fifo_ea[r_rd_ptr][c_EA_W-1:2];
        w_pop        = mem_en_out && !w_flush;
        w_capture    = (r_state == c_WAIT) && (r_lat_cnt == c_LAT_LAST) && !w_flush;
        w_release    = (r_state == c_HOLD) && read_in && !w_flush;
    end

    // ------------------------------------------------------------------
    // Pending-load FIFO
    // ------------------------------------------------------------------
    // Entry storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo_ea[r_wr_ptr]     <= w_ea[c_EA_W-1:0];
            r_fifo_funct3[r_wr_ptr] <= funct3_in;
            r_fifo_rob[r_wr_ptr]    <= rob_ix_in;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // In-flight load and result
    // ------------------------------------------------------------------
    // Size/sign the returning BRAM word for the in-flight load (little-endian).
    always_comb begin
        w_byte = mem_data_in[7:0];
        case (r_inf_off)
            2'd0:    w_byte = mem_data_in[7:0];
            2'd1:    w_byte = mem_data_in[15:8];
            2'd2:    w_byte = mem_data_in[23:16];
            default: w_byte = mem_data_in[31:24];
        endcase
        // Halfword select ignores ea[0].
        w_half = r_inf_off[1] ? mem_data_in[31:16] : mem_data_in[15:0];
        case (r_inf_funct3)
            c_F3_LB:  w_extract = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  w_extract = {{16{w_half[15]}}, w_half};
            c_F3_LBU: w_extract = {24'd0, w_byte};
            c_F3_LHU: w_extract = {16'd0, w_half};
            // LW and the unused encodings return the whole word.
            default:  w_extract = mem_data_in;
        endcase
    end

    // Latch the popped load, time the BRAM read, then capture and hold the result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_lat_cnt    <= '0;
            r_inf_off    <= '0;
            r_inf_funct3 <= '0;
            r_inf_rob    <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            rob_ix_out   <= '0;
        end else if (w_flush) begin
            // Late data from a cancelled read is never captured once in IDLE.
            r_lat_cnt <= '0;
            valid_out <= 1'b0;
        end else begin
            if (w_pop) begin
                r_lat_cnt    <= c_LAT_INIT;
                r_inf_off    <= r_fifo_ea[r_rd_ptr][1:0];
                r_inf_funct3 <= r_fifo_funct3[r_rd_ptr];
                r_inf_rob    <= r_fifo_rob[r_rd_ptr];
            end else if ((r_state == c_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
            end

            if (w_capture) begin
                valid_out  <= 1'b1;
                data_out   <= w_extract;
                rob_ix_out <= r_inf_rob;
            end else if (w_release) begin
                valid_out  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_buffer.sv
// ============================================================================
//  Module   : tb_load_buffer
//  Purpose  : Self-checking bench for load_buffer: directed vector table for
//             address/extract/latency plus queue-fill, reset-in-flight and
//             (with LB_FLUSH_EN) flush sequences. Includes a 2-clock BRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_load_buffer;

    localparam int DEPTH = 4;
    localparam int RL    = 2;
    localparam int AW    = 6;
    localparam int RW    = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          valid_in;
    logic [31:0]   rval1_in;
    logic [31:0]   rval2_in;
    logic [2:0]    funct3_in;
    logic [RW-1:0] rob_ix_in;
    logic          ready_out;
    logic          mem_en_out;
    logic [AW-1:0] mem_addr_out;
    logic [31:0]   mem_data_in;
    logic          read_in;
    logic          valid_out;
    logic [31:0]   data_out;
    logic [RW-1:0] rob_ix_out;
`ifdef LB_FLUSH_EN
    logic          flush_in;
`endif

    int total = 0;
    int bad   = 0;

    load_buffer #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .ADDR_WIDTH   (AW),
        .ROB_IX_WIDTH (RW)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .valid_in     (valid_in),
        .rval1_in     (rval1_in),
        .rval2_in     (rval2_in),
        .funct3_in    (funct3_in),
        .rob_ix_in    (rob_ix_in),
        .ready_out    (ready_out),
        .mem_en_out   (mem_en_out),
        .mem_addr_out (mem_addr_out),
        .mem_data_in  (mem_data_in),
        .read_in      (read_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .rob_ix_out   (rob_ix_out)
`ifdef LB_FLUSH_EN
        ,
        .flush_in     (flush_in)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Two-clock BRAM: registered address, registered data.
    logic [31:0]   bram [64];
    logic [AW-1:0] b_addr_q = '0;
    always @(posedge clk_in) begin
        if (mem_en_out) b_addr_q <= mem_addr_out;
        mem_data_in <= bram[b_addr_q];
    end

    typedef struct {
        logic [31:0]   r1;
        logic [31:0]   r2;
        logic [2:0]    f3;
        logic [RW-1:0] rob;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] r1, input logic [31:0] r2,
                         input logic [2:0] f3, input logic [RW-1:0] rob);
        valid_in  = 1'b1;
        rval1_in  = r1;
        rval2_in  = r2;
        funct3_in = f3;
        rob_ix_in = rob;
    endtask

    // One load from an idle unit with exact-latency checks and a delayed read.
    task automatic load_one(input vec_t v, input int idx);
        drive(v.r1, v.r2, v.f3, v.rob);
        tick();                                        // E0: accept
        valid_in = 1'b0;
        chk($sformatf("v%0d_mem_en", idx), 32'(mem_en_out), 32'd1);
        chk($sformatf("v%0d_addr", idx), 32'(mem_addr_out), 32'(v.addr));
        tick();                                        // E1: request
        chk($sformatf("v%0d_vld_e1", idx), 32'(valid_out), 32'd0);
        tick();                                        // E2
        chk($sformatf("v%0d_vld_e2", idx), 32'(valid_out), 32'd0);
        tick();                                        // E3: capture
        chk($sformatf("v%0d_vld_e3", idx), 32'(valid_out), 32'd1);
        chk($sformatf("v%0d_data", idx), data_out, v.data);
        chk($sformatf("v%0d_rob", idx), 32'(rob_ix_out), 32'(v.rob));
        tick();                                        // E4: still held
        chk($sformatf("v%0d_hold", idx), {31'd0, valid_out} + 32'(rob_ix_out), 32'd1 + 32'(v.rob));
        read_in = 1'b1;
        tick();                                        // E5: taken
        read_in = 1'b0;
        chk($sformatf("v%0d_drop", idx), 32'(valid_out), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n;

        for (int i = 0; i < 64; i++) bram[i] = 32'h0;
        bram[5] = 32'hDEADBEEF;
        bram[7] = 32'h12345678;

        //           r1            r2            f3      rob   addr  data
        vecs[0]  = '{32'd16,       32'd4,        3'b010, 3'd3, 6'd5, 32'hDEADBEEF};
        vecs[1]  = '{32'd21,       32'd0,        3'b000, 3'd1, 6'd5, 32'hFFFFFFBE};
        vecs[2]  = '{32'd21,       32'd0,        3'b100, 3'd2, 6'd5, 32'h000000BE};
        vecs[3]  = '{32'd22,       32'd0,        3'b001, 3'd4, 6'd5, 32'hFFFFDEAD};
        vecs[4]  = '{32'd22,       32'd0,        3'b101, 3'd5, 6'd5, 32'h0000DEAD};
        vecs[5]  = '{32'h20,       32'hFFFFFFFC, 3'b010, 3'd6, 6'd7, 32'h12345678};
        vecs[6]  = '{32'd20,       32'd0,        3'b000, 3'd7, 6'd5, 32'hFFFFFFEF};
        vecs[7]  = '{32'd23,       32'd0,        3'b001, 3'd0, 6'd5, 32'hFFFFDEAD};
        vecs[8]  = '{32'd21,       32'd0,        3'b011, 3'd2, 6'd5, 32'hDEADBEEF};
        vecs[9]  = '{32'd28,       32'd0,        3'b111, 3'd1, 6'd7, 32'h12345678};
        vecs[10] = '{32'd31,       32'd0,        3'b100, 3'd5, 6'd7, 32'h00000012};
        vecs[11] = '{32'd100,      32'hFFFFFFB8, 3'b000, 3'd6, 6'd7, 32'h00000078};
        vecs[12] = '{32'd22,       32'd0,        3'b110, 3'd4, 6'd5, 32'hDEADBEEF};

        rst_in    = 1'b1;
        valid_in  = 1'b0;
        rval1_in  = '0;
        rval2_in  = '0;
        funct3_in = '0;
        rob_ix_in = '0;
        read_in   = 1'b0;
`ifdef LB_FLUSH_EN
        flush_in  = 1'b0;
`endif
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        // Reset state
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_rob", 32'(rob_ix_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_mem_en", 32'(mem_en_out), 32'd0);

        // Table-driven loads
        for (int i = 0; i < 13; i++) begin
            load_one(vecs[i], i);
        end

        // Queue fill with read_in held low: DEPTH+1 accepted, rest ignored
        for (int i = 0; i < 7; i++) begin
            drive((i % 2 == 1) ? 32'd28 : 32'd20, 32'd0, 3'b010, RW'(i));
            tick();
            chk($sformatf("fill_ready%0d", i), 32'(ready_out), (i < 4) ? 32'd1 : 32'd0);
        end
        valid_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (valid_out !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("fill_vld%0d", k), 32'(valid_out), 32'd1);
            chk($sformatf("fill_rob%0d", k), 32'(rob_ix_out), 32'(k));
            chk($sformatf("fill_data%0d", k), data_out, (k % 2 == 1) ? 32'h12345678 : 32'hDEADBEEF);
            read_in = 1'b1;
            tick();
            read_in = 1'b0;
            chk($sformatf("fill_drop%0d", k), 32'(valid_out), 32'd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid_out) seen = 1'b1;
        end
        chk("fill_no_extra", 32'(seen), 32'd0);
        chk("fill_ready_end", 32'(ready_out), 32'd1);

        // Reset while a load is in WAIT and another is queued
        drive(32'd20, 32'd0, 3'b010, 3'd1);
        tick();                                        // E0
        drive(32'd28, 32'd0, 3'b010, 3'd2);
        tick();                                        // E1: first in WAIT
        valid_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_ready", 32'(ready_out), 32'd1);
        chk("arst_mem_en", 32'(mem_en_out), 32'd0);
        #1 rst_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid_out || mem_en_out) seen = 1'b1;
        end
        chk("arst_no_result", 32'(seen), 32'd0);
        load_one(vecs[5], 50);

`ifdef LB_FLUSH_EN
        // Flush with one load in WAIT and two queued; simultaneous push dropped
        drive(32'd20, 32'd0, 3'b010, 3'd1);
        tick();                                        // E0
        drive(32'd28, 32'd0, 3'b010, 3'd2);
        tick();                                        // E1: request
        drive(32'd20, 32'd0, 3'b010, 3'd3);
        tick();                                        // E2
        drive(32'd28, 32'd0, 3'b010, 3'd4);
        flush_in = 1'b1;
        tick();                                        // E3: flush beats capture and push
        flush_in = 1'b0;
        valid_in = 1'b0;
        chk("fl_valid", 32'(valid_out), 32'd0);
        chk("fl_mem_en", 32'(mem_en_out), 32'd0);
        chk("fl_ready", 32'(ready_out), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid_out || mem_en_out) seen = 1'b1;
        end
        chk("fl_no_result", 32'(seen), 32'd0);
        load_one(vecs[1], 60);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
